vram_slot_arbiter: RTL

- Parametrised N-client VRAM slot arbiter for the V9958-Super VDP, generalising the fixed CPU/sprite/command/display VRAM arbitration.
- Grants at most one access per dot cycle, at the slot phase of DOTSTATE.
- Display fetch always wins. Strict-priority clients come next. Remaining clients share slots round-robin, with a starvation promoter.
- Drives the registered VRAM request bus (IRAMADR, PRAMWE_N, size, write data) toward the memory controller.

---
 rtl/vram_slot_arbiter_if.sv | 38 +++
 rtl/vram_slot_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/vram_slot_arbiter_if.sv
// Signal bundle between the VRAM slot arbiter, its clients, the display fetch
// and the memory-controller request bus.
interface vram_slot_arbiter_if #(
  parameter int NUM_CLIENTS = 4,
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 32
);
  logic [1:0]               DOTSTATE;
  logic                     disp_req;
  logic [ADDR_W-1:0]        disp_addr;
  logic [NUM_CLIENTS-1:0]   client_req;
  logic [NUM_CLIENTS-1:0]   client_we;
  logic [NUM_CLIENTS*ADDR_W-1:0] client_addr;
  logic [NUM_CLIENTS*DATA_W-1:0] client_wdata;
  logic [NUM_CLIENTS*2-1:0] client_size;
  logic [NUM_CLIENTS-1:0]   client_ack;
  logic [NUM_CLIENTS-1:0]   client_rd_tgl;
  logic [ADDR_W-1:0]        IRAMADR;
  logic                     PRAMWE_N;
  logic [1:0]               PRAM_SIZE;
  logic [DATA_W-1:0]        PRAMDBO;
  logic                     grant_valid;
  logic [2:0]               grant_id;

  modport master (
    output DOTSTATE, disp_req, disp_addr, client_req, client_we, client_addr,
           client_wdata, client_size,
    input  client_ack, client_rd_tgl, IRAMADR, PRAMWE_N, PRAM_SIZE, PRAMDBO,
           grant_valid, grant_id
  );

  modport slave (
    input  DOTSTATE, disp_req, disp_addr, client_req, client_we, client_addr,
           client_wdata, client_size,
    output client_ack, client_rd_tgl, IRAMADR, PRAMWE_N, PRAM_SIZE, PRAMDBO,
           grant_valid, grant_id
  );
endinterface

// File: rtl/vram_slot_arbiter.sv
// N-client VRAM slot arbiter: display first, then strict-priority clients,
// then starvation-promoted and round-robin clients, one grant per dot slot.
module vram_slot_arbiter #(
  parameter int                     NUM_CLIENTS = 4,
  parameter int                     ADDR_W      = 18,
  parameter int                     DATA_W      = 32,
  parameter logic [1:0]             SLOT_PHASE  = 2'b10,
  parameter logic [NUM_CLIENTS-1:0] PRIO_MASK   = NUM_CLIENTS'(1),
  parameter int                     MAX_WAIT    = 3
) (
  input  logic               CLK21M,
  input  logic               RESET,
  vram_slot_arbiter_if.slave bus
);
  localparam logic [3:0] WAIT_SAT = 4'(MAX_WAIT);

  logic                   slot;
  logic [NUM_CLIENTS-1:0] pending;
  logic [NUM_CLIENTS-1:0] grant_vec;
  logic [NUM_CLIENTS-1:0] ack_vec;
  logic [NUM_CLIENTS-1:0] rd_tgl_vec;
  logic [3:0]             wait_cnt [NUM_CLIENTS];
  logic [2:0]             ptr_reg;
  logic                   win_found;
  logic                   win_rr;
  logic [2:0]             win_id;
  logic [ADDR_W-1:0]      sel_addr;
  logic [DATA_W-1:0]      sel_wdata;
  logic [1:0]             sel_size;
  logic                   sel_we;
  logic [ADDR_W-1:0]      iramadr_reg;
  logic                   pramwe_n_reg;
  logic [1:0]             pram_size_reg;
  logic [DATA_W-1:0]      pramdbo_reg;
  logic                   grant_valid_reg;
  logic [2:0]             grant_id_reg;

  assign slot    = (bus.DOTSTATE == SLOT_PHASE);
  assign pending = bus.client_req ^ ack_vec;

  // Loops run downward so the lowest qualifying index is the one left standing.
  always_comb begin
    win_found = 1'b0;
    win_rr    = 1'b0;
    win_id    = 3'd0;
    for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
      if (pending[i] && PRIO_MASK[i]) begin
        win_found = 1'b1;
        win_id    = 3'(i);
      end
    end
    if (!win_found) begin
      for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
        if (pending[i] && !PRIO_MASK[i] && wait_cnt[i] == WAIT_SAT) begin
          win_found = 1'b1;
          win_id    = 3'(i);
        end
      end
    end
    // Wrapped candidates (<= pointer) are overridden by any above the pointer.
    if (!win_found) begin
      for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
        if (pending[i] && !PRIO_MASK[i] && 3'(i) <= ptr_reg) begin
          win_found = 1'b1;
          win_rr    = 1'b1;
          win_id    = 3'(i);
        end
      end
      for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
        if (pending[i] && !PRIO_MASK[i] && 3'(i) > ptr_reg) begin
          win_found = 1'b1;
          win_rr    = 1'b1;
          win_id    = 3'(i);
        end
      end
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_size  = 2'b00;
    sel_we    = 1'b0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (win_id == 3'(i)) begin
        sel_addr  = bus.client_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = bus.client_wdata[i*DATA_W +: DATA_W];
        sel_size  = bus.client_size[i*2 +: 2];
        sel_we    = bus.client_we[i];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_client
    logic       ack_reg;
    logic       rd_tgl_reg;
    logic [3:0] wait_reg;

    assign grant_vec[gi] = slot && !bus.disp_req && win_found && (win_id == 3'(gi));

    always_ff @(posedge CLK21M or posedge RESET) begin
      if (RESET) begin
        ack_reg    <= 1'b0;
        rd_tgl_reg <= 1'b0;
        wait_reg   <= 4'd0;
      end else begin
        if (grant_vec[gi]) begin
          ack_reg <= ~ack_reg;
          if (!bus.client_we[gi])
            rd_tgl_reg <= ~rd_tgl_reg;
        end
        // Display-owned slots count as lost slots too.
        if (slot && !PRIO_MASK[gi]) begin
          if (grant_vec[gi] || !pending[gi])
            wait_reg <= 4'd0;
          else if (wait_reg != WAIT_SAT)
            wait_reg <= wait_reg + 4'd1;
        end
      end
    end

    assign ack_vec[gi]    = ack_reg;
    assign rd_tgl_vec[gi] = rd_tgl_reg;
    assign wait_cnt[gi]   = wait_reg;
  end

  always_ff @(posedge CLK21M or posedge RESET) begin
    if (RESET) begin
      iramadr_reg     <= '1;
      pramwe_n_reg    <= 1'b1;
      pram_size_reg   <= 2'b01;
      pramdbo_reg     <= '0;
      grant_valid_reg <= 1'b0;
      grant_id_reg    <= 3'd0;
      ptr_reg         <= 3'd0;
    end else begin
      pramwe_n_reg    <= 1'b1;
      grant_valid_reg <= 1'b0;
      if (slot) begin
        if (bus.disp_req) begin
          iramadr_reg   <= bus.disp_addr;
          pram_size_reg <= 2'b10;
        end else if (win_found) begin
          iramadr_reg     <= sel_addr;
          pram_size_reg   <= sel_size;
          pramwe_n_reg    <= ~sel_we;
          grant_valid_reg <= 1'b1;
          grant_id_reg    <= win_id;
          if (sel_we)
            pramdbo_reg <= sel_wdata;
          if (win_rr)
            ptr_reg <= win_id;
        end
      end
    end
  end

  assign bus.client_ack    = ack_vec;
  assign bus.client_rd_tgl = rd_tgl_vec;
  assign bus.IRAMADR       = iramadr_reg;
  assign bus.PRAMWE_N      = pramwe_n_reg;
  assign bus.PRAM_SIZE     = pram_size_reg;
  assign bus.PRAMDBO       = pramdbo_reg;
  assign bus.grant_valid   = grant_valid_reg;
  assign bus.grant_id      = grant_id_reg;
endmodule
